// File: rtl/mmio_pkg.sv
// mmio_pkg: shared I/O address map and region-select type for the MMIO responder
package mmio_pkg;
  localparam logic [15:0] IO_BASE   = 16'hFF00;
  localparam logic [15:0] ADR_SW    = 16'hFF00;
  localparam logic [15:0] ADR_LED   = 16'hFF01;
  localparam logic [15:0] ADR_TIMER = 16'hFF02;
  localparam logic [15:0] ADR_TCLR  = 16'hFF03;
  typedef enum logic [1:0] {REG_RAM, REG_IO, REG_NONE} region_t;
endpackage

// File: rtl/mmio_ram.sv
// mmio_ram: single-port synchronous read-first RAM (clk, we, addr, wdata -> rdata)
module mmio_ram #(
  parameter int WIDTH = 16,
  parameter int RAM_DEPTH = 1024
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(RAM_DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata
);
  logic [WIDTH-1:0] mem [RAM_DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/mmio_mem_responder.sv
// mmio_mem_responder: CPU memory/IO responder; ports clk, reset, adr, memOut, memwrite_a/b -> memdata, switches -> leds, addr_err; MMIO_TIMER_EN adds TIMER/TCLR
module mmio_mem_responder
  import mmio_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int RAM_DEPTH = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] memOut,
  input  logic             memwrite_a,
  input  logic             memwrite_b,
  output logic [WIDTH-1:0] memdata,
  input  logic [15:0]      switches,
  output logic [15:0]      leds,
  output logic             addr_err
);
  localparam int AW = $clog2(RAM_DEPTH);
  logic is_ram, is_io, is_led, is_tclr, wr_ram, wr_led, err;
  region_t region, region_q;
  logic [15:0] sw_s1, sw_s2, led_q, timer, io_d, io_q;
  logic [WIDTH-1:0] ram_q;
  always_comb begin
    is_ram  = 32'(adr) < 32'(RAM_DEPTH);
    is_io   = adr >= WIDTH'(IO_BASE) && adr <= WIDTH'(ADR_TCLR);
    is_led  = adr == WIDTH'(ADR_LED);
    is_tclr = adr == WIDTH'(ADR_TCLR);
    region  = is_ram ? REG_RAM : is_io ? REG_IO : REG_NONE;
    wr_ram  = ~reset & memwrite_a & ~memwrite_b & is_ram;
    wr_led  = memwrite_b & ~memwrite_a & is_led;
    // TCLR stays a legal write target even when the timer is compiled out
    err     = (memwrite_a & (memwrite_b | ~is_ram)) | (memwrite_b & ~(is_led | is_tclr));
    // I/O value captured at the edge, so LED reads see the pre-write value
    io_d    = adr[1:0] == 2'd0 ? sw_s2 : adr[1:0] == 2'd1 ? led_q : adr[1:0] == 2'd2 ? timer : '0;
    memdata = region_q == REG_RAM ? ram_q : region_q == REG_IO ? WIDTH'(io_q) : '0;
  end
  mmio_ram #(.WIDTH(WIDTH), .RAM_DEPTH(RAM_DEPTH)) u_ram (
    .clk(clk), .we(wr_ram), .addr(adr[AW-1:0]), .wdata(memOut), .rdata(ram_q)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      region_q <= REG_NONE;
      io_q     <= '0;
      led_q    <= '0;
      sw_s1    <= '0;
      sw_s2    <= '0;
      addr_err <= 1'b0;
    end else begin
      region_q <= region;
      io_q     <= io_d;
      sw_s1    <= switches;
      sw_s2    <= sw_s1;
      if (wr_led) led_q <= 16'(memOut);
      addr_err <= addr_err | err;
    end
  end
  assign leds = led_q;
`ifdef MMIO_TIMER_EN
  logic wr_tclr;
  assign wr_tclr = memwrite_b & ~memwrite_a & is_tclr;
  always_ff @(posedge clk)
    if (reset) timer <= '0;
    else timer <= wr_tclr ? '0 : timer + 16'd1;
`else
  assign timer = '0;
`endif
endmodule

// File: tb/tb_mmio_mem_responder.sv
// tb_mmio_mem_responder: directed scoreboard bench for mmio_mem_responder
module tb_mmio_mem_responder;
  logic clk = 0, reset = 1, memwrite_a = 0, memwrite_b = 0, addr_err;
  logic [15:0] adr = 0, memOut = 0, memdata, switches = 0, leds;
  typedef struct {logic chk; logic [15:0] val;} exp_t;
  exp_t sbq[$];
  logic [15:0] mdl [0:1023];
  logic [15:0] led_m = 0, s1m = 0, s2m = 0, tm = 0;
  logic err_m = 0;
  int checks = 0, fails = 0;
  mmio_mem_responder dut (
    .clk(clk), .reset(reset), .adr(adr), .memOut(memOut), .memwrite_a(memwrite_a),
    .memwrite_b(memwrite_b), .memdata(memdata), .switches(switches), .leds(leds), .addr_err(addr_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask
  task automatic cyc(input logic [15:0] a, input logic wa, input logic wb, input logic [15:0] d, input logic chk);
    exp_t e;
    @(negedge clk);
    adr = a; memwrite_a = wa; memwrite_b = wb; memOut = d;
    e.chk = chk;
    if (reset) e.val = 16'h0;
    else if (a < 16'd1024) e.val = mdl[a[9:0]];
    else if (a == 16'hFF00) e.val = s2m;
    else if (a == 16'hFF01) e.val = led_m;
`ifdef MMIO_TIMER_EN
    else if (a == 16'hFF02) e.val = tm;
`endif
    else e.val = 16'h0;
    sbq.push_back(e);
    @(posedge clk);
    if (reset) begin
      led_m = 0; err_m = 0; s1m = 0; s2m = 0; tm = 0;
    end else begin
      if (wa && !wb && a < 16'd1024) mdl[a[9:0]] = d;
      if (wb && !wa && a == 16'hFF01) led_m = d;
      if ((wa && wb) || (wa && a >= 16'd1024) || (wb && a != 16'hFF01 && a != 16'hFF03)) err_m = 1;
      s2m = s1m; s1m = switches;
      tm = (wb && !wa && a == 16'hFF03) ? 16'h0 : tm + 16'd1;
    end
    #1;
    e = sbq.pop_front();
    if (e.chk) check($sformatf("memdata@%h", a), memdata, e.val);
    check("leds", leds, led_m);
    check("addr_err", {15'b0, addr_err}, {15'b0, err_m});
  endtask
  initial begin
    cyc(16'h0000, 0, 0, 0, 1);
    cyc(16'h0000, 1, 0, 16'hDEAD, 1);
    reset = 0;
    cyc(16'h0005, 1, 0, 16'h1234, 0);
    cyc(16'h0005, 0, 0, 0, 1);
    cyc(16'h0007, 1, 0, 16'hAAAA, 0);
    cyc(16'h0007, 1, 0, 16'h5555, 1);
    cyc(16'h0007, 0, 0, 0, 1);
    cyc(16'h0001, 1, 0, 16'h0101, 0);
    cyc(16'h03FF, 1, 0, 16'h7E57, 0);
    cyc(16'h03FF, 0, 0, 0, 1);
    cyc(16'hFF01, 0, 1, 16'hC3C3, 1);
    cyc(16'hFF01, 0, 0, 0, 1);
    cyc(16'h8000, 0, 0, 0, 1);
    cyc(16'hFF05, 0, 0, 0, 1);
    cyc(16'h0001, 1, 1, 16'hFFFF, 0);
    cyc(16'h0001, 0, 0, 0, 1);
    reset = 1;
    cyc(16'h0005, 1, 0, 16'h9999, 1);
    reset = 0;
    cyc(16'h0005, 0, 0, 0, 1);
    cyc(16'hFF01, 0, 1, 16'h00F0, 0);
    cyc(16'hFF00, 0, 1, 16'h1111, 1);
    cyc(16'hFF01, 0, 0, 0, 1);
    reset = 1;
    cyc(16'h0000, 0, 0, 0, 1);
    reset = 0;
    cyc(16'h0400, 1, 0, 16'h2222, 0);
    reset = 1;
    cyc(16'h0000, 0, 0, 0, 1);
    reset = 0;
    switches = 16'hBEEF;
    for (int i = 0; i < 5; i++) cyc(16'hFF00, 0, 0, 0, 1);
    switches = 16'h0F0F;
    for (int i = 0; i < 4; i++) cyc(16'hFF00, 0, 0, 0, 1);
`ifdef MMIO_TIMER_EN
    cyc(16'hFF03, 0, 1, 0, 1);
    cyc(16'hFF02, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) cyc(16'h0000, 0, 0, 0, 0);
    cyc(16'hFF02, 0, 0, 0, 1);
    check("timer_model_10", tm, 16'd11);
    for (int i = 0; i < 70000 && tm != 16'hFFFF; i++) cyc(16'h0000, 0, 0, 0, 0);
    cyc(16'hFF02, 0, 0, 0, 1);
    cyc(16'hFF02, 0, 0, 0, 1);
`else
    cyc(16'hFF02, 0, 0, 0, 1);
    cyc(16'hFF03, 0, 1, 16'h1234, 1);
    cyc(16'hFF03, 0, 0, 0, 1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/mmio_mem_responder.md
MMIO_MEM_RESPONDER -- requirements
Module: mmio_mem_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data and address width.
REQ-002 SHALL have parameter RAM_DEPTH, default 1024: RAM words, power of two, at most 32768.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-005 SHALL have port adr, input, WIDTH bits: word address from the CPU.
REQ-006 SHALL have port memOut, input, WIDTH bits: write data from the CPU.
REQ-007 SHALL have port memwrite_a, input, 1 bit: RAM-region write strobe.
REQ-008 SHALL have port memwrite_b, input, 1 bit: I/O-region write strobe.
REQ-009 SHALL have port memdata, output, WIDTH bits: registered read data to the CPU.
REQ-010 SHALL have port switches, input, 16 bits: asynchronous board switches.
REQ-011 SHALL have port leds, output, 16 bits: LED register.
REQ-012 SHALL have port addr_err, output, 1 bit: sticky decode-error flag.

Function
REQ-013 Address map SHALL be:
- RAM: 0x0000 to RAM_DEPTH-1.
- SW (read-only): 0xFF00.
- LED (read/write): 0xFF01.
- TIMER (read-only): 0xFF02.
- TCLR (write clears the timer, reads 0x0000): 0xFF03.
- Every other address is unmapped.
REQ-014 Read latency SHALL be exactly 1 cycle: memdata in cycle N+1 reflects adr sampled in cycle N, every cycle, with no request strobe.
REQ-015 Reads of unmapped addresses SHALL return 0x0000 and SHALL NOT set addr_err.
REQ-016 memwrite_a with adr in the RAM range SHALL write memOut to RAM[adr] at that edge.
REQ-017 memwrite_b with adr at LED or TCLR SHALL perform that register's write at that edge.
REQ-018 A write-and-read of the same RAM address in one cycle SHALL be read-first: the old data appears on memdata.
REQ-019 A write-and-read of LED in one cycle SHALL also return the old LED value.
REQ-020 The following SHALL be ignored and SHALL set addr_err for the following cycle onward until reset:
- memwrite_a outside the RAM range.
- memwrite_b outside {LED, TCLR}, including a write to SW or TIMER.
REQ-021 memwrite_a and memwrite_b asserted together SHALL perform no write and SHALL set addr_err.
REQ-022 switches SHALL pass through a 2-flop synchronizer; an SW read returns the second-stage value, so a switch change is visible 3 cycles after it is applied.
REQ-023 TIMER SHALL be a 16-bit counter, incrementing by 1 every cycle and wrapping 0xFFFF to 0x0000.
REQ-024 A TCLR write SHALL load the timer with 0x0000 at that edge, overriding the increment.
REQ-025 leds SHALL be driven directly from the LED register.

Reset
REQ-026 While reset is high at an edge, the following SHALL all clear to 0: memdata, leds, addr_err, timer, synchronizer flops.
REQ-027 While reset is high, all writes SHALL be suppressed and RAM contents SHALL be retained.
REQ-028 The first read result after reset deasserts SHALL appear 1 cycle after the first post-reset address.

Configuration
REQ-029 With macro MMIO_TIMER_EN defined, TIMER and TCLR SHALL behave per REQ-023 and REQ-024.
REQ-030 Without MMIO_TIMER_EN:
- No counter logic SHALL exist.
- Reads of 0xFF02 and 0xFF03 SHALL return 0x0000.
- Writes to 0xFF03 SHALL be ignored without setting addr_err.

Structure
REQ-031 The following constants SHALL live in shared package mmio_pkg: the I/O addresses, the I/O base 0xFF00, and a region-select enum {REG_RAM, REG_IO, REG_NONE}.
REQ-032 RAM SHALL be a separate sub-module, mmio_ram: single port, synchronous read-first, parameterized by WIDTH and RAM_DEPTH.
REQ-033 The read mux SHALL use the registered region select.

Verification
REQ-034 Write 0x1234 to RAM 0x0005 via memwrite_a, then read 0x0005 -> memdata=0x1234 exactly one cycle after the read address.
REQ-035 In one cycle, read 0x0007 (holding 0xAAAA) while writing 0x5555 to 0x0007 -> memdata=0xAAAA; reading the same address next cycle -> 0x5555.
REQ-036 Test the decode-error cases:
- memwrite_b to 0xFF00 -> addr_err=1 the next cycle, leds unchanged.
- Both strobes to 0x0001 -> RAM[1] unchanged.
- Reset -> addr_err=0.
REQ-037 Set switches=0xBEEF, then read 0xFF00 each cycle -> 0xBEEF first returned for an address presented 2 cycles after the switch change, appearing on memdata 3 cycles after it.
REQ-038 With MMIO_TIMER_EN: write TCLR, then read TIMER 10 cycles later -> a value 10 greater than the post-clear value. Force the timer to 0xFFFF -> next cycle it reads 0x0000.
REQ-039 Without MMIO_TIMER_EN: read 0xFF02 -> 0x0000 with addr_err=0.
